// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, including the multicycle divider busy FSM.
// Optional performance counters are built when STALL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_rd,
    input  logic              EX_DivStart,
    input  logic              EX_BranchTaken,
    input  logic              MEM_Exception,
    input  logic              IF_Busy,
    input  logic              MEM_Busy,
    output logic              PC_Wr,
    output logic              ID_Wr,
    output logic              EXE_Wr,
    output logic              MEM_Wr,
    output logic              WB_Wr,
    output logic              ID_Flush,
    output logic              EXE_Flush,
    output logic              MEM_Flush,
    output logic              WB_Flush,
    output logic              Div_Busy,
    output logic              Div_Done,
    output logic [PERF_W-1:0] Perf_StallCycles,
    output logic [PERF_W-1:0] Perf_FlushEvents
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    div_state_t state;
    logic [5:0] count;
    logic       load_use;
    logic       div_stall;

    assign load_use  = EX_MemRead && (EX_rd != 5'd0) && ((EX_rd == ID_rs) || (EX_rd == ID_rt));
    assign div_stall = (state == BUSY) || ((state == IDLE) && EX_DivStart);

    // Fixed-priority resolution; each branch masks everything below it.
    always_comb begin
        PC_Wr     = 1'b1;
        ID_Wr     = 1'b1;
        EXE_Wr    = 1'b1;
        MEM_Wr    = 1'b1;
        WB_Wr     = 1'b1;
        ID_Flush  = 1'b0;
        EXE_Flush = 1'b0;
        MEM_Flush = 1'b0;
        WB_Flush  = 1'b0;
        if (rst) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Wr    = 1'b0;
            WB_Wr     = 1'b0;
            ID_Flush  = 1'b1;
            EXE_Flush = 1'b1;
            MEM_Flush = 1'b1;
            WB_Flush  = 1'b1;
        end else if (MEM_Exception) begin
            ID_Flush  = 1'b1;
            EXE_Flush = 1'b1;
            MEM_Flush = 1'b1;
        end else if (MEM_Busy) begin
            PC_Wr    = 1'b0;
            ID_Wr    = 1'b0;
            EXE_Wr   = 1'b0;
            MEM_Wr   = 1'b0;
            WB_Flush = 1'b1;
        end else if (div_stall) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Flush = 1'b1;
        end else if (load_use) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            ID_Flush = IF_Busy;
        end else if (IF_Busy) begin
            PC_Wr    = 1'b0;
            ID_Flush = 1'b1;
        end
    end

    assign Div_Busy = !rst && (state == BUSY);
    assign Div_Done = !rst && (state == DONE) && !MEM_Exception && !MEM_Busy;

    // Divider sequencer: an exception aborts it, a D-cache miss freezes it in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 6'd0;
        end else if (MEM_Exception) begin
            state <= IDLE;
            count <= 6'd0;
        end else if (!MEM_Busy) begin
            unique case (state)
                IDLE: begin
                    if (EX_DivStart) begin
                        state <= BUSY;
                        count <= DIV_LOAD;
                    end
                end
                BUSY: begin
                    if (count <= 6'd1) begin
                        state <= DONE;
                        count <= 6'd0;
                    end else begin
                        count <= count - 6'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= 6'd0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PC_Wr)
                stall_cnt <= stall_cnt + PERF_W'(1);
            if (ID_Flush || EXE_Flush || MEM_Flush || WB_Flush)
                flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end

    assign Perf_StallCycles = stall_cnt;
    assign Perf_FlushEvents = flush_cnt;
`else
    assign Perf_StallCycles = '0;
    assign Perf_FlushEvents = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle model pushes expected controls, compared at negedge.
module tb_pipe_hazard_ctrl;

    localparam int N = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, EX_rd;
    logic        EX_MemRead, EX_DivStart, EX_BranchTaken, MEM_Exception, IF_Busy, MEM_Busy;
    logic        PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
    logic        ID_Flush, EXE_Flush, MEM_Flush, WB_Flush, Div_Busy, Div_Done;
    logic [31:0] Perf_StallCycles, Perf_FlushEvents;

    pipe_hazard_ctrl #(.DIV_CYCLES(N), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_MemRead(EX_MemRead),
        .EX_rd(EX_rd), .EX_DivStart(EX_DivStart), .EX_BranchTaken(EX_BranchTaken),
        .MEM_Exception(MEM_Exception), .IF_Busy(IF_Busy), .MEM_Busy(MEM_Busy),
        .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
        .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush), .WB_Flush(WB_Flush),
        .Div_Busy(Div_Busy), .Div_Done(Div_Done),
        .Perf_StallCycles(Perf_StallCycles), .Perf_FlushEvents(Perf_FlushEvents)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } sb_entry_t;

    sb_entry_t   sb_queue[$];
    int          checks = 0;
    int          errors = 0;
    logic [10:0] last_obs;

    // Divider model tracks cycles elapsed since the start cycle, frozen while MEM_Busy.
    logic        m_active = 1'b0;
    int          m_elapsed = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    wire [10:0] obs = {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr,
                       ID_Flush, EXE_Flush, MEM_Flush, WB_Flush, Div_Busy, Div_Done};

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [10:0] model_ctrl(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                               input logic mr, input logic [4:0] rd, input logic ds,
                                               input logic br, input logic ex, input logic ib, input logic mb);
        logic [4:0] wr;
        logic [3:0] fl;
        logic       lu, busy, in_done;
        if (r) return 11'b00000_1111_00;
        lu      = mr && (rd != 5'd0) && ((rd == rs) || (rd == rt));
        busy    = m_active && (m_elapsed <= N - 2);
        in_done = m_active && (m_elapsed == N - 1);
        wr = 5'b11111;
        fl = 4'b0000;
        if (ex)                         fl = 4'b1110;
        else if (mb)                    begin wr = 5'b00001; fl = 4'b0001; end
        else if (busy || (!m_active && ds)) begin wr = 5'b00011; fl = 4'b0010; end
        else if (lu)                    begin wr = 5'b00111; fl = 4'b0100; end
        else if (br)                    fl = ib ? 4'b1000 : 4'b0000;
        else if (ib)                    begin wr = 5'b01111; fl = 4'b1000; end
        return {wr, fl, busy, in_done && !ex && !mb};
    endfunction

    task automatic apply_stimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic mr, input logic [4:0] rd, input logic ds,
                                  input logic br, input logic ex, input logic ib, input logic mb,
                                  input string tag);
        sb_entry_t e, got;
        rst = r; ID_rs = rs; ID_rt = rt; EX_MemRead = mr; EX_rd = rd;
        EX_DivStart = ds; EX_BranchTaken = br; MEM_Exception = ex; IF_Busy = ib; MEM_Busy = mb;
        if (r) begin
            m_active = 1'b0; m_elapsed = 0; m_stall = 0; m_flush = 0;
        end
        e.ctrl = model_ctrl(r, rs, rt, mr, rd, ds, br, ex, ib, mb);
`ifdef STALL_PERF_EN
        e.stall = m_stall;
        e.flush = m_flush;
`else
        e.stall = 0;
        e.flush = 0;
`endif
        sb_queue.push_back(e);
        @(negedge clk);
        got = sb_queue.pop_front();
        last_obs = obs;
        check_output({tag, "_ctrl"}, obs, got.ctrl);
        check_output({tag, "_perf_stall"}, Perf_StallCycles, got.stall);
        check_output({tag, "_perf_flush"}, Perf_FlushEvents, got.flush);
        @(posedge clk);
        if (!r) begin
            if (!e.ctrl[10]) m_stall++;
            if (|e.ctrl[5:2]) m_flush++;
            if (ex) m_active = 1'b0;
            else if (!mb) begin
                if (!m_active) begin
                    if (ds) begin m_active = 1'b1; m_elapsed = 1; end
                end else if (m_elapsed == N - 1) m_active = 1'b0;
                else m_elapsed++;
            end
        end
        #1;
    endtask

    task automatic idle_step(input string tag);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        int busy_cnt, pc_low, done_at, done_cnt;
        rst = 1'b1; ID_rs = 0; ID_rt = 0; EX_rd = 0; EX_MemRead = 0; EX_DivStart = 0;
        EX_BranchTaken = 0; MEM_Exception = 0; IF_Busy = 0; MEM_Busy = 0;
        @(posedge clk); #1;
        apply_stimulus(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, "reset_a");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_b");

        for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "if_busy");
`ifdef STALL_PERF_EN
        check_output("perf_stall_10", Perf_StallCycles, 10);
        check_output("perf_flush_10", Perf_FlushEvents, 10);
`else
        check_output("perf_stall_off", Perf_StallCycles, 0);
        check_output("perf_flush_off", Perf_FlushEvents, 0);
`endif
        idle_step("idle");
        apply_stimulus(0, 5, 0, 1, 5, 0, 0, 0, 0, 0, "loaduse_rs");
        apply_stimulus(0, 1, 7, 1, 7, 0, 0, 0, 0, 0, "loaduse_rt");
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "loaduse_r0");
        apply_stimulus(0, 5, 0, 0, 5, 0, 0, 0, 0, 0, "no_load");
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "branch");
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "branch_ifbusy");
        apply_stimulus(0, 5, 0, 1, 5, 0, 1, 0, 0, 0, "branch_loaduse");
        apply_stimulus(0, 5, 0, 1, 5, 0, 0, 0, 0, 1, "membusy_over_lu");
        apply_stimulus(0, 5, 0, 1, 5, 0, 1, 1, 1, 1, "exception_top");

        busy_cnt = 0; pc_low = 0; done_at = 0;
        for (int k = 1; k <= 60; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "div_full");
            if (last_obs[1]) busy_cnt++;
            if (!last_obs[10]) pc_low++;
            if (last_obs[0]) begin done_at = k; break; end
        end
        check_output("div_busy_cycles", busy_cnt, 31);
        check_output("div_stall_cycles", pc_low, 32);
        check_output("div_done_cycle", done_at, 33);
        idle_step("after_div");
        check_output("after_div_busy", last_obs[1], 0);

        done_cnt = 0;
        for (int k = 1; k <= 11; k++)
            apply_stimulus(0, 0, 0, 0, 0, 1, 0, (k == 11), 0, 0, "div_exc");
        for (int k = 0; k < 40; k++) begin
            idle_step("post_exc");
            if (k == 0) check_output("exc_busy_cleared", last_obs[1], 0);
            if (last_obs[0]) done_cnt++;
        end
        check_output("exc_no_done", done_cnt, 0);

        done_at = 0;
        for (int k = 1; k <= 60; k++) begin
            apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, (k >= 10 && k <= 13), "div_membusy");
            if (last_obs[0]) begin done_at = k; break; end
        end
        check_output("membusy_done_cycle", done_at, 37);
        idle_step("after_membusy");

        for (int k = 0; k < 6; k++) apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "div_pre_rst");
        apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, "rst_mid_div");
        idle_step("after_rst_div");
        check_output("rst_div_idle", last_obs[1], 0);

        for (int k = 0; k < 400; k++) begin
            apply_stimulus(($urandom_range(199) == 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
                           1'($urandom_range(1)), 5'($urandom_range(3)), ($urandom_range(5) == 0),
                           ($urandom_range(3) == 0), ($urandom_range(24) == 0),
                           ($urandom_range(3) == 0), ($urandom_range(7) == 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
